cones_pipe: RTL and testbench
=============================

Name: cones_pipe

Overview:
Parametrised elastic register pipeline of DEPTH stages over a WIDTH-bit bus. Each stage optionally inverts its data, selected per stage at elaboration. Each stage has a valid/ready handshake, so it supports backpressure, full throughput and bubble collapsing. It is the general logic-cone test and benchmark block: every stage boundary is a register cut between combinational cones.

Parameters:
- WIDTH, 2, data bus width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- INV_MASK, {DEPTH{1'b1}}, DEPTH-bit mask. Bit i=1 means stage i stores ~(incoming data); bit i=0 means stage i stores the incoming data unchanged. Stage 0 is nearest the input.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  pipeline accepts the beat this cycle.
- in_data  in  WIDTH  upstream data.
- out_valid  out  1  stage DEPTH-1 holds a beat.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  WIDTH  stage DEPTH-1 data register.
- flush  in  1  synchronous discard of all in-flight beats.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- State per stage i: v[i] (1 bit) and d[i] (WIDTH bits).
- Transfer rule: a beat transfers on an edge where valid&&ready. Stage i ready: rdy[i] = !v[i] || rdy[i+1], with rdy[DEPTH] = out_ready. Ready is combinational, so the pipeline collapses bubbles.
- in_ready = rdy[0] && !flush.
- Stage update, when rdy[i]:
  - v[i] <= v[i-1], with v[-1] = in_valid && !flush.
  - d[i] <= f_i(d[i-1]) only when the incoming valid is 1, with d[-1] = in_data.
  - f_i = bitwise NOT if INV_MASK[i], else identity.
- When !rdy[i]: stage i holds v[i] and d[i].
- Data is never updated by a bubble. out_data holds its last value while out_valid=0.
- Outputs: out_valid = v[DEPTH-1]; out_data = d[DEPTH-1]; occupancy = popcount(v), combinational.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+DEPTH-1 (DEPTH cycles of registers), provided there is no stall.
- Throughput: 1 beat/cycle when out_ready=1. With out_ready=0 the pipeline absorbs exactly DEPTH beats, then in_ready=0.
- Simultaneous push and pop when full: allowed. in_ready=1 because rdy propagates from out_ready=1, and occupancy is unchanged.
- Order is strictly preserved. No beat is dropped or duplicated except by flush or reset.
- flush=1 at edge N:
  - All v cleared after edge N.
  - A beat presented in that cycle is not accepted (in_ready=0).
  - d registers are left unchanged.
  - flush dominates out_ready. The out_valid beat is discarded even if out_ready=1; downstream must treat that cycle as no transfer.
- Reset (rst_n=0 at an edge):
  - All v <= 0 and all d <= 0.
  - Outputs become out_valid=0, out_data=0, occupancy=0, in_ready=1 (when flush=0).
  - Mid-operation reset discards all in-flight beats. Reset dominates flush.
- Net transform: out_data = in_data XOR {WIDTH{parity(INV_MASK)}}, where parity(INV_MASK) = popcount(INV_MASK) mod 2.

Optional Feature:
- Macro: CONES_PIPE_PARITY_EN.
- When defined:
  - Each stage carries an extra register p[i].
  - Stage 0 loads p = ^in_data.
  - Stage i stores p[i] = p[i-1] ^ (INV_MASK[i] & WIDTH[0]), i.e. the expected parity is tracked through inversions.
  - New output parity_err (1 bit, reset 0), sticky: set on any edge where out_valid && (^out_data != p[DEPTH-1]). It is cleared only by reset, not by flush.
  - p is reset to 0.
- When undefined: no p registers and no parity_err port.

Test Plan:
1. WIDTH=2, DEPTH=2, INV_MASK=2'b11, out_ready=1: push 2'b01 at cycle 0 -> out_valid=1 with out_data=2'b01 after 2 edges; occupancy 1 then 0.
2. Same config, INV_MASK=2'b01: stream 0,1,2,3 back-to-back -> out_data 3,2,1,0 on consecutive cycles; in_ready stays 1 throughout.
3. Backpressure, DEPTH=2: out_ready=0, offer beats A=0,B=1,C=2 -> A and B accepted, in_ready=0 while C is offered, occupancy=2. Then out_ready=1 -> out_data sequence A',B',C' in order, with C accepted in the same cycle A' drains.
4. Full with simultaneous push/pop: DEPTH=3 full, out_ready=1 and in_valid=1 for 5 cycles -> occupancy stays 3 and 5 beats exit in order.
5. flush=1 with occupancy=2 and in_valid=1 -> in_ready=0 that cycle; next cycle occupancy=0 and out_valid=0; out_data unchanged.
6. rst_n=0 for 1 edge with occupancy=2 -> out_valid=0, out_data=0, occupancy=0. With CONES_PIPE_PARITY_EN, WIDTH=3, INV_MASK=2'b10: 20 random beats -> parity_err stays 0.

Source files
------------

// File: rtl/cones_pipe.sv
// cones_pipe: elastic register pipeline of DEPTH stages over a WIDTH-bit bus.
// Each stage is a register cut with a valid/ready handshake and may invert its
// data (INV_MASK bit per stage). Ready is combinational back through the
// stages, so bubbles collapse and a full pipe streams one beat per cycle.
// Optional feature macro: CONES_PIPE_PARITY_EN adds per-stage expected-parity
// tracking and a sticky parity_err output.
module cones_pipe #(
  parameter int               WIDTH    = 2,
  parameter int               DEPTH    = 2,
  parameter logic [DEPTH-1:0] INV_MASK = {DEPTH{1'b1}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef CONES_PIPE_PARITY_EN
  ,
  output logic                       parity_err
`endif
);

  localparam int OCC_W = $clog2(DEPTH + 1);

`ifdef CONES_PIPE_PARITY_EN
  // An inversion flips the parity of the word only when the width is odd.
  localparam logic WIDTH_ODD = ((WIDTH % 2) == 1) ? 1'b1 : 1'b0;
`endif

  // Flattened view of every stage's state, gathered from the generate blocks.
  logic [DEPTH-1:0] v_all;
  logic [WIDTH-1:0] d_all [DEPTH];
`ifdef CONES_PIPE_PARITY_EN
  logic [DEPTH-1:0] p_all;
`endif

  // rdy[i]: stage i can take a beat this cycle; rdy[DEPTH] is the sink.
  logic [DEPTH:0]   rdy;
  logic [OCC_W-1:0] occ_count;

  // Ready ripples from the output back toward the input, top stage first.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !v_all[i] || rdy[i+1];
    end
  end

  // Population count of the stage valid bits.
  always_comb begin
    occ_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_count = occ_count + OCC_W'(v_all[i]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             up_valid;
      logic [WIDTH-1:0] up_data;
      logic             load;
      logic             v_q;
      logic             v_d;
      logic [WIDTH-1:0] d_q;
      logic [WIDTH-1:0] d_d;
`ifdef CONES_PIPE_PARITY_EN
      logic             up_par;
      logic             p_q;
      logic             p_d;
`endif

      // Stage 0 is fed by the pipeline input, later stages by their predecessor.
      if (gi == 0) begin : g_head
        assign up_valid = in_valid && !flush;
        assign up_data  = in_data;
`ifdef CONES_PIPE_PARITY_EN
        assign up_par   = ^in_data;
`endif
      end else begin : g_body
        assign up_valid = v_all[gi-1];
        assign up_data  = d_all[gi-1];
`ifdef CONES_PIPE_PARITY_EN
        assign up_par   = p_all[gi-1];
`endif
      end

      // Data only moves with a real beat; bubbles and flushes leave it alone.
      assign load = rdy[gi] && up_valid && !flush;

      // Next-state: flush empties the stage, otherwise advance when ready.
      always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
          v_d = 1'b0;
        end else if (rdy[gi]) begin
          v_d = up_valid;
        end
        if (load) begin
          d_d = INV_MASK[gi] ? ~up_data : up_data;
        end
`ifdef CONES_PIPE_PARITY_EN
        p_d = p_q;
        if (load) begin
          p_d = up_par ^ (INV_MASK[gi] & WIDTH_ODD);
        end
`endif
      end

      // Stage registers with synchronous active-low reset.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          d_q <= '0;
`ifdef CONES_PIPE_PARITY_EN
          p_q <= 1'b0;
`endif
        end else begin
          v_q <= v_d;
          d_q <= d_d;
`ifdef CONES_PIPE_PARITY_EN
          p_q <= p_d;
`endif
        end
      end

      assign v_all[gi] = v_q;
      assign d_all[gi] = d_q;
`ifdef CONES_PIPE_PARITY_EN
      assign p_all[gi] = p_q;
`endif
    end
  endgenerate

`ifdef CONES_PIPE_PARITY_EN
  logic parity_err_q;

  // Sticky error: output word parity disagrees with the tracked parity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else if (v_all[DEPTH-1] && ((^d_all[DEPTH-1]) != p_all[DEPTH-1])) begin
      parity_err_q <= 1'b1;
    end
  end

  assign parity_err = parity_err_q;
`endif

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = v_all[DEPTH-1];
  assign out_data  = d_all[DEPTH-1];
  assign occupancy = occ_count;

endmodule

// File: tb/tb_cones_pipe.sv
// Directed self-checking bench for cones_pipe. Three default-build instances
// cover inversion masks, depths and widths; a fourth is added when
// CONES_PIPE_PARITY_EN is defined to exercise the parity tracker.
module tb_cones_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic rst_n = 1'b0;
  logic flush = 1'b0;

  // u_a: WIDTH=2, DEPTH=2, INV_MASK=11 -> net identity
  logic       a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [1:0] a_in_data = '0;
  logic       a_in_ready, a_out_valid;
  logic [1:0] a_out_data, a_occ;
  // u_b: WIDTH=2, DEPTH=2, INV_MASK=01 -> net inversion
  logic       b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [1:0] b_in_data = '0;
  logic       b_in_ready, b_out_valid;
  logic [1:0] b_out_data, b_occ;
  // u_c: WIDTH=4, DEPTH=3, INV_MASK=111 -> net inversion
  logic       c_in_valid = 1'b0, c_out_ready = 1'b0;
  logic [3:0] c_in_data = '0;
  logic       c_in_ready, c_out_valid;
  logic [3:0] c_out_data;
  logic [1:0] c_occ;
`ifdef CONES_PIPE_PARITY_EN
  logic a_perr, b_perr, c_perr;
  // u_d: WIDTH=3, DEPTH=2, INV_MASK=10 -> net inversion
  logic       d_in_valid = 1'b0, d_out_ready = 1'b0;
  logic [2:0] d_in_data = '0;
  logic       d_in_ready, d_out_valid, d_perr;
  logic [2:0] d_out_data;
  logic [1:0] d_occ;
`endif

  cones_pipe #(.WIDTH(2), .DEPTH(2), .INV_MASK(2'b11)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .flush(flush), .occupancy(a_occ)
`ifdef CONES_PIPE_PARITY_EN
    , .parity_err(a_perr)
`endif
  );

  cones_pipe #(.WIDTH(2), .DEPTH(2), .INV_MASK(2'b01)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .flush(1'b0), .occupancy(b_occ)
`ifdef CONES_PIPE_PARITY_EN
    , .parity_err(b_perr)
`endif
  );

  cones_pipe #(.WIDTH(4), .DEPTH(3), .INV_MASK(3'b111)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .flush(1'b0), .occupancy(c_occ)
`ifdef CONES_PIPE_PARITY_EN
    , .parity_err(c_perr)
`endif
  );

`ifdef CONES_PIPE_PARITY_EN
  cones_pipe #(.WIDTH(3), .DEPTH(2), .INV_MASK(2'b10)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_data(d_out_data), .flush(1'b0), .occupancy(d_occ), .parity_err(d_perr)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 2'd0) begin n_bad++; $display("FAIL reset_a_data: got %0d want 0", a_out_data); end
    n_cmp++; if (a_occ !== 2'd0) begin n_bad++; $display("FAIL reset_a_occ: got %0d want 0", a_occ); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_a_in_ready: got %b want 1", a_in_ready); end
    n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_valid: got %b want 0", b_out_valid); end
    n_cmp++; if (c_out_data !== 4'd0) begin n_bad++; $display("FAIL reset_c_data: got %0d want 0", c_out_data); end
    n_cmp++; if (c_occ !== 2'd0) begin n_bad++; $display("FAIL reset_c_occ: got %0d want 0", c_occ); end
`ifdef CONES_PIPE_PARITY_EN
    n_cmp++; if (d_perr !== 1'b0) begin n_bad++; $display("FAIL reset_d_perr: got %b want 0", d_perr); end
`endif
    $display("reset: outputs idle");
  endtask

  task automatic test_single();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 2'b01;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL single_in_ready: got %b want 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    #1;
    n_cmp++; if (a_occ !== 2'd1) begin n_bad++; $display("FAIL single_occ_e1: got %0d want 1", a_occ); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_e1: got %b want 0", a_out_valid); end
    tick();
    n_cmp++; if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid_e2: got %b want 1", a_out_valid); end
    n_cmp++; if (a_out_data !== 2'b01) begin n_bad++; $display("FAIL single_data_e2: got %0d want 1", a_out_data); end
    n_cmp++; if (a_occ !== 2'd1) begin n_bad++; $display("FAIL single_occ_e2: got %0d want 1", a_occ); end
    tick();
    n_cmp++; if (a_occ !== 2'd0) begin n_bad++; $display("FAIL single_occ_e3: got %0d want 0", a_occ); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_e3: got %b want 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 2'b01) begin n_bad++; $display("FAIL single_hold_e3: got %0d want 1", a_out_data); end
    $display("single: beat 1 out 1");
  endtask

  task automatic test_stream();
    logic [1:0] exp_d;
    b_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      b_in_valid = (c < 4);
      b_in_data  = 2'(c);
      #1;
      if (c < 4) begin
        n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready[%0d]: got %b want 1", c, b_in_ready); end
      end
      tick();
      if (c >= 1 && c <= 4) begin
        exp_d = 2'(4 - c);
        n_cmp++; if (b_out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want 1", c, b_out_valid); end
        n_cmp++; if (b_out_data !== exp_d) begin n_bad++; $display("FAIL stream_data[%0d]: got %0d want %0d", c, b_out_data, exp_d); end
        $display("stream: cycle %0d out %0d", c, b_out_data);
      end else begin
        n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_idle[%0d]: got %b want 0", c, b_out_valid); end
      end
    end
    b_in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 2'd0;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept_A: got %b want 1", a_in_ready); end
    tick();
    a_in_data = 2'd1;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept_B: got %b want 1", a_in_ready); end
    tick();
    a_in_data = 2'd2;
    #1;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_block_C: got %b want 0", a_in_ready); end
    n_cmp++; if (a_occ !== 2'd2) begin n_bad++; $display("FAIL bp_occ_full: got %0d want 2", a_occ); end
    tick();
    n_cmp++; if (a_out_data !== 2'd0) begin n_bad++; $display("FAIL bp_hold_A: got %0d want 0", a_out_data); end
    a_out_ready = 1'b1;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept_C: got %b want 1", a_in_ready); end
    n_cmp++; if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_A: got %b want 1", a_out_valid); end
    tick();
    a_in_valid = 1'b0;
    #1;
    n_cmp++; if (a_out_data !== 2'd1) begin n_bad++; $display("FAIL bp_data_B: got %0d want 1", a_out_data); end
    n_cmp++; if (a_occ !== 2'd2) begin n_bad++; $display("FAIL bp_occ_B: got %0d want 2", a_occ); end
    tick();
    n_cmp++; if (a_out_data !== 2'd2) begin n_bad++; $display("FAIL bp_data_C: got %0d want 2", a_out_data); end
    n_cmp++; if (a_occ !== 2'd1) begin n_bad++; $display("FAIL bp_occ_C: got %0d want 1", a_occ); end
    tick();
    n_cmp++; if (a_occ !== 2'd0) begin n_bad++; $display("FAIL bp_occ_empty: got %0d want 0", a_occ); end
    $display("backpressure: A,B,C drained in order");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d;
    c_out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      c_in_valid = 1'b1;
      c_in_data  = 4'(k);
      #1;
      n_cmp++; if (c_in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_fill[%0d]: got %b want 1", k, c_in_ready); end
      tick();
    end
    c_in_valid = 1'b0;
    #1;
    n_cmp++; if (c_occ !== 2'd3) begin n_bad++; $display("FAIL b2b_occ_full: got %0d want 3", c_occ); end
    n_cmp++; if (c_in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full_ready: got %b want 0", c_in_ready); end
    for (int k = 0; k < 5; k++) begin
      c_in_valid  = 1'b1;
      c_in_data   = 4'(4 + k);
      c_out_ready = 1'b1;
      exp_d       = ~4'(1 + k);
      #1;
      n_cmp++; if (c_occ !== 2'd3) begin n_bad++; $display("FAIL b2b_occ[%0d]: got %0d want 3", k, c_occ); end
      n_cmp++; if (c_in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, c_in_ready); end
      n_cmp++; if (c_out_data !== exp_d) begin n_bad++; $display("FAIL b2b_data[%0d]: got %0h want %0h", k, c_out_data, exp_d); end
      $display("back_to_back: in %0h out %0h", c_in_data, c_out_data);
      tick();
    end
    c_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_d = ~4'(6 + k);
      #1;
      n_cmp++; if (c_out_data !== exp_d) begin n_bad++; $display("FAIL b2b_drain[%0d]: got %0h want %0h", k, c_out_data, exp_d); end
      tick();
    end
    n_cmp++; if (c_occ !== 2'd0) begin n_bad++; $display("FAIL b2b_empty: got %0d want 0", c_occ); end
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 2'd2;
    tick();
    a_in_data = 2'd3;
    tick();
    n_cmp++; if (a_occ !== 2'd2) begin n_bad++; $display("FAIL flush_pre_occ: got %0d want 2", a_occ); end
    flush       = 1'b1;
    a_in_data   = 2'd1;
    a_out_ready = 1'b1;
    #1;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", a_in_ready); end
    tick();
    flush      = 1'b0;
    a_in_valid = 1'b0;
    #1;
    n_cmp++; if (a_occ !== 2'd0) begin n_bad++; $display("FAIL flush_occ: got %0d want 0", a_occ); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 2'd2) begin n_bad++; $display("FAIL flush_data_hold: got %0d want 2", a_out_data); end
    a_in_valid = 1'b1;
    a_in_data  = 2'd3;
    tick();
    a_in_valid = 1'b0;
    tick();
    n_cmp++; if (a_out_data !== 2'd3) begin n_bad++; $display("FAIL flush_recover: got %0d want 3", a_out_data); end
    tick();
    $display("flush: pipeline emptied, data held");
  endtask

  task automatic test_mid_reset();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 2'd1;
    tick();
    a_in_data = 2'd3;
    tick();
    a_in_valid = 1'b0;
    #1;
    n_cmp++; if (a_occ !== 2'd2) begin n_bad++; $display("FAIL mrst_pre_occ: got %0d want 2", a_occ); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 2'd0) begin n_bad++; $display("FAIL mrst_data: got %0d want 0", a_out_data); end
    n_cmp++; if (a_occ !== 2'd0) begin n_bad++; $display("FAIL mrst_occ: got %0d want 0", a_occ); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_in_ready: got %b want 1", a_in_ready); end
    $display("mid_reset: in-flight beats discarded");
  endtask

`ifdef CONES_PIPE_PARITY_EN
  task automatic test_parity();
    logic [2:0] exp_q [$];
    logic [2:0] exp_d;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while (got < 20 && cyc < 400) begin
      d_in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
      d_in_data   = 3'($urandom_range(0, 7));
      d_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (d_in_valid && d_in_ready) begin
        exp_q.push_back(~d_in_data);
        sent++;
      end
      if (d_out_valid && d_out_ready) begin
        exp_d = exp_q.pop_front();
        n_cmp++; if (d_out_data !== exp_d) begin n_bad++; $display("FAIL parity_data[%0d]: got %0d want %0d", got, d_out_data, exp_d); end
        got++;
      end
      tick();
      cyc++;
    end
    d_in_valid = 1'b0;
    n_cmp++; if (got !== 20) begin n_bad++; $display("FAIL parity_timeout: got %0d beats want 20", got); end
    n_cmp++; if (d_perr !== 1'b0) begin n_bad++; $display("FAIL parity_err: got %b want 0", d_perr); end
    $display("parity: %0d beats checked", got);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_mid_reset();
`ifdef CONES_PIPE_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
